// File: rtl/tick_sequencer.sv
// tick_sequencer -- emits a train of evenly spaced tick pulses.
//
// An accepted start latches the period and the repetition count, then the
// block runs for reps ticks, one every max(period,1) cycles, and finishes
// with a one-cycle done pulse. An abort while running ends the train with a
// one-cycle aborted pulse instead.
//
// Optional feature macro: TICK_SEQ_PAUSE_EN adds the pause input, which
// freezes a running sequence.
//
// Ports:
//   clk      in   clock, all state updates on its rising edge
//   rst_n    in   asynchronous active-low reset
//   start    in   request to begin a sequence (honoured only in IDLE)
//   abort    in   request to terminate the running sequence (RUN only)
//   period   in   cycles per tick (0 is treated as 1)
//   reps     in   ticks per sequence (0 completes immediately)
//   pause    in   freeze the running sequence (TICK_SEQ_PAUSE_EN only)
//   busy     out  high exactly while the sequence runs
//   tick     out  one-cycle pulse at the end of each period
//   done     out  one-cycle pulse on normal completion
//   aborted  out  one-cycle pulse on abort
//   rep_cnt  out  ticks issued in the current or last sequence
//
// Request semantics: start, abort and pause are level requests sampled on
// the rising clk edge; there is no ready/acknowledge. A request presented in
// a state that does not accept it is dropped, not queued.

module tick_sequencer #(
   parameter int CNT_W = 32,
   parameter int REP_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   input  logic [CNT_W-1:0] period,
   input  logic [REP_W-1:0] reps,
`ifdef TICK_SEQ_PAUSE_EN
   input  logic             pause,
`endif
   output logic             busy,
   output logic             tick,
   output logic             done,
   output logic             aborted,
   output logic [REP_W-1:0] rep_cnt
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2,
      ABRT = 2'd3
   } state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] count, count_nxt;
   logic [CNT_W-1:0] per_q, per_nxt;
   logic [REP_W-1:0] reps_q, reps_nxt;
   logic [REP_W-1:0] rep_cnt_nxt;
   logic [REP_W-1:0] rep_cnt_inc;
   logic             at_last;
   logic             stall;

`ifdef TICK_SEQ_PAUSE_EN
   // pause is registered before use so that tick depends only on flops.
   // A pause seen at an edge therefore freezes the following cycle.
   logic pause_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pause_q <= 1'b0;
      end else begin
         pause_q <= pause;
      end
   end

   assign stall = pause_q;
`else
   assign stall = 1'b0;
`endif

   // per_q is at least 1 whenever the FSM is in RUN, so per_q-1 never wraps
   // where at_last is actually consumed.
   assign at_last     = (count == (per_q - CNT_W'(1)));
   assign rep_cnt_inc = rep_cnt + REP_W'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         count   <= '0;
         per_q   <= '0;
         reps_q  <= '0;
         rep_cnt <= '0;
      end else begin
         state   <= state_nxt;
         count   <= count_nxt;
         per_q   <= per_nxt;
         reps_q  <= reps_nxt;
         rep_cnt <= rep_cnt_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      count_nxt   = count;
      per_nxt     = per_q;
      reps_nxt    = reps_q;
      rep_cnt_nxt = rep_cnt;
      busy        = 1'b0;
      tick        = 1'b0;
      done        = 1'b0;
      aborted     = 1'b0;

      case (state)
         IDLE: begin
            if (start) begin
               per_nxt     = (period == '0) ? CNT_W'(1) : period;
               reps_nxt    = reps;
               count_nxt   = '0;
               rep_cnt_nxt = '0;
               state_nxt   = (reps == '0) ? DONE : RUN;
            end
         end

         RUN: begin
            busy = 1'b1;
            if (!stall) begin
               if (at_last) begin
                  tick        = 1'b1;
                  count_nxt   = '0;
                  rep_cnt_nxt = rep_cnt_inc;
                  if (rep_cnt_inc == reps_q) begin
                     state_nxt = DONE;
                  end
               end else begin
                  count_nxt = count + CNT_W'(1);
               end
            end
            // Abort overrides completion; the tick above is still emitted.
            if (abort) begin
               state_nxt = ABRT;
            end
         end

         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end

         ABRT: begin
            aborted   = 1'b1;
            state_nxt = IDLE;
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_tick_sequencer.sv
// tb_tick_sequencer -- directed self-checking bench for tick_sequencer.
// A monitor logs, relative to the cycle in which start was presented, the
// cycles carrying tick, done and aborted, and counts busy cycles. Each
// scenario then compares those logs against hand-computed expectations.

module tb_tick_sequencer;

   localparam int CNT_W = 32;
   localparam int REP_W = 16;

   logic             clk;
   logic             rst_n;
   logic             start;
   logic             abort;
   logic [CNT_W-1:0] period;
   logic [REP_W-1:0] reps;
`ifdef TICK_SEQ_PAUSE_EN
   logic             pause;
`endif
   logic             busy;
   logic             tick;
   logic             done;
   logic             aborted;
   logic [REP_W-1:0] rep_cnt;

   int n_checks = 0;
   int n_errors = 0;

   int cyc  = 0;
   int base = 0;
   int tick_q[$];
   int done_q[$];
   int abrt_q[$];
   int busy_cnt = 0;
   logic [31:0] exp_q[$];

   tick_sequencer #(.CNT_W(CNT_W), .REP_W(REP_W)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .abort   (abort),
      .period  (period),
      .reps    (reps),
`ifdef TICK_SEQ_PAUSE_EN
      .pause   (pause),
`endif
      .busy    (busy),
      .tick    (tick),
      .done    (done),
      .aborted (aborted),
      .rep_cnt (rep_cnt)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // monitor: samples 2 time units after each rising edge
   always @(posedge clk) begin
      #2;
      cyc++;
      if (tick)    tick_q.push_back(cyc - base);
      if (done)    done_q.push_back(cyc - base);
      if (aborted) abrt_q.push_back(cyc - base);
      if (busy)    busy_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic clear_logs();
      tick_q.delete();
      done_q.delete();
      abrt_q.delete();
      busy_cnt = 0;
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Called at a negedge in IDLE; returns at the negedge of RUN cycle 1.
   task automatic start_seq(input logic [CNT_W-1:0] p, input logic [REP_W-1:0] r);
      period = p;
      reps   = r;
      start  = 1'b1;
      clear_logs();
      base = cyc;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Compare the logged tick cycles against exp_q.
   task automatic check_ticks(input string tag);
      check({tag, "_ntick"}, tick_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < tick_q.size(); i++) begin
         check($sformatf("%s_tick%0d", tag, i), tick_q[i], exp_q[i]);
      end
   endtask

   task automatic check_done_at(input string tag, input int at);
      check({tag, "_ndone"}, done_q.size(), 1);
      if (done_q.size() > 0) check({tag, "_done_at"}, done_q[0], at);
   endtask

   initial begin
      rst_n  = 1'b0;
      start  = 1'b0;
      abort  = 1'b0;
      period = '0;
      reps   = '0;
`ifdef TICK_SEQ_PAUSE_EN
      pause  = 1'b0;
`endif
      wait_cyc(3);
      check("rst_busy", busy, 0);
      check("rst_tick", tick, 0);
      check("rst_done", done, 0);
      check("rst_aborted", aborted, 0);
      check("rst_rep_cnt", rep_cnt, 0);
      rst_n = 1'b1;
      wait_cyc(2);

      // period 4, reps 3: ticks at 4, 8, 12, done at 13
      start_seq(4, 3);
      wait_cyc(15);
      exp_q = '{4, 8, 12};
      check_ticks("p4r3");
      check_done_at("p4r3", 13);
      check("p4r3_busy", busy_cnt, 12);
      check("p4r3_rep_cnt", rep_cnt, 3);
      check("p4r3_nabrt", abrt_q.size(), 0);

      // period 0 and 1 behave identically: back-to-back ticks
      start_seq(0, 2);
      wait_cyc(4);
      exp_q = '{1, 2};
      check_ticks("p0r2");
      check_done_at("p0r2", 3);
      check("p0r2_rep_cnt", rep_cnt, 2);

      start_seq(1, 2);
      wait_cyc(4);
      exp_q = '{1, 2};
      check_ticks("p1r2");
      check_done_at("p1r2", 3);
      check("p1r2_busy", busy_cnt, 2);

      // reps 0: immediate done, no tick, never busy
      start_seq(4, 0);
      wait_cyc(4);
      exp_q.delete();
      check_ticks("r0");
      check_done_at("r0", 1);
      check("r0_busy", busy_cnt, 0);
      check("r0_rep_cnt", rep_cnt, 0);

      // abort in the cycle of the 2nd tick
      start_seq(5, 4);
      wait_cyc(9);
      abort = 1'b1;
      wait_cyc(1);
      abort = 1'b0;
      wait_cyc(4);
      exp_q = '{5, 10};
      check_ticks("abrt");
      check("abrt_naborted", abrt_q.size(), 1);
      if (abrt_q.size() > 0) check("abrt_at", abrt_q[0], 11);
      check("abrt_ndone", done_q.size(), 0);
      check("abrt_rep_cnt", rep_cnt, 2);
      check("abrt_busy", busy_cnt, 10);

      // start mid-run and in DONE are ignored; period change has no effect
      start_seq(3, 5);
      wait_cyc(3);
      start  = 1'b1;
      period = 7;
      wait_cyc(1);
      start = 1'b0;
      wait_cyc(11);
      start = 1'b1;
      reps  = 1;
      wait_cyc(1);
      start = 1'b0;
      wait_cyc(3);
      exp_q = '{3, 6, 9, 12, 15};
      check_ticks("restart");
      check_done_at("restart", 16);
      check("restart_busy", busy_cnt, 15);
      check("restart_rep_cnt", rep_cnt, 5);
      // abort in IDLE is ignored and rep_cnt holds
      abort = 1'b1;
      wait_cyc(1);
      abort = 1'b0;
      wait_cyc(2);
      check("idle_abort_n", abrt_q.size(), 0);
      check("idle_rep_cnt_hold", rep_cnt, 5);

      // asynchronous reset in the middle of a run
      start_seq(2, 3);
      wait_cyc(3);
      check("prerst_tick", tick, 1);
      check("prerst_busy", busy, 1);
      check("prerst_rep_cnt", rep_cnt, 1);
      rst_n = 1'b0;
      #1;
      check("midrst_busy", busy, 0);
      check("midrst_tick", tick, 0);
      check("midrst_done", done, 0);
      check("midrst_aborted", aborted, 0);
      check("midrst_rep_cnt", rep_cnt, 0);
      clear_logs();
      wait_cyc(2);
      rst_n = 1'b1;
      wait_cyc(2);
      check("postrst_ndone", done_q.size(), 0);
      check("postrst_nabrt", abrt_q.size(), 0);
      start_seq(2, 1);
      wait_cyc(3);
      exp_q = '{2};
      check_ticks("postrst");
      check_done_at("postrst", 3);

`ifdef TICK_SEQ_PAUSE_EN
      // pause for 3 cycles after cycle 2 pushes the first tick to cycle 7
      start_seq(4, 2);
      wait_cyc(2);
      pause = 1'b1;
      wait_cyc(3);
      pause = 1'b0;
      wait_cyc(8);
      exp_q = '{7, 11};
      check_ticks("pause");
      check_done_at("pause", 12);
      check("pause_busy", busy_cnt, 11);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
